// File: rtl/spi_pkg.sv
// Shared constants, types and bit-order helper for spi_master.
// SPI_MASTER_MSB_FIRST_EN switches both directions to MSB-first ordering.
package spi_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_SLAVES = 3;
  localparam int CNT_W      = $clog2(DATA_WIDTH);
  localparam int SEL_W      = 2;

  localparam logic [0:NUM_SLAVES-1] CS_IDLE = '1;
  localparam logic [SEL_W-1:0]      SEL_MAX = SEL_W'(NUM_SLAVES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT} state_t;

  typedef struct packed {
    logic [SEL_W-1:0]      sel;
    logic [DATA_WIDTH-1:0] data;
  } spi_req_t;

  // Maps the k-th bit on the wire to its position in the data word.
  function automatic logic [CNT_W-1:0] bit_idx(input logic [CNT_W-1:0] k);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return CNT_W'(DATA_WIDTH - 1) - k;
`else
    return k;
`endif
  endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// TX/RX word registers and bit counter for spi_master.
// Bit ordering comes from spi_pkg::bit_idx (SPI_MASTER_MSB_FIRST_EN).
module spi_shift_reg
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  setup,
  input  logic                  shift,
  input  logic                  miso,
  output logic                  tx_first,
  output logic                  tx_next,
  output logic [DATA_WIDTH-1:0] rx_next,
  output logic                  done
);
  logic [DATA_WIDTH-1:0] tx, rx;
  logic [CNT_W-1:0]      cnt, cnt_inc;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign done     = (cnt == CNT_W'(DATA_WIDTH - 1));
  assign tx_first = tx[bit_idx('0)];
  assign tx_next  = tx[bit_idx(cnt_inc)];

  // RX word including the MISO bit sampled at this edge, so the final
  // word can be published on the same edge the last bit arrives.
  always_comb begin
    rx_next               = rx;
    rx_next[bit_idx(cnt)] = miso;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx  <= '0;
      rx  <= '0;
      cnt <= '0;
    end else if (load) begin
      tx  <= load_data;
      rx  <= '0;
      cnt <= '0;
    end else if (setup) begin
      cnt <= '0;
    end else if (shift) begin
      rx  <= rx_next;
      cnt <= done ? '0 : cnt_inc;
    end
  end
endmodule

// File: rtl/spi_master.sv
// Single-clock SPI master: one 8-bit full-duplex word per transfer, 3 chip selects.
// Bit order set by SPI_MASTER_MSB_FIRST_EN (see spi_pkg); LSB first by default.
module spi_master
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_W-1:0]      slaveSelect,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  SCLK,
  output logic [0:NUM_SLAVES-1] CS,
  output logic                  MOSI,
  input  logic                  MISO
);
  state_t                state_q, state_d;
  logic [0:NUM_SLAVES-1] cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic                  load, setup, shift;
  logic                  tx_first, tx_next, done;
  logic [DATA_WIDTH-1:0] rx_next;
  spi_req_t              req;

  assign req = '{sel: slaveSelect, data: masterDataToSend};

  spi_shift_reg u_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(req.data),
    .setup    (setup),
    .shift    (shift),
    .miso     (MISO),
    .tx_first (tx_first),
    .tx_next  (tx_next),
    .rx_next  (rx_next),
    .done     (done)
  );

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    mdr_d   = mdr_q;
    load    = 1'b0;
    setup   = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && req.sel <= SEL_MAX) begin
          load             = 1'b1;
          cs_d             = CS_IDLE;
          cs_d[req.sel]    = 1'b0;
          state_d          = SETUP;
        end
      end
      SETUP: begin
        setup   = 1'b1;
        mosi_d  = tx_first;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (done) begin
          mdr_d   = rx_next;
          cs_d    = CS_IDLE;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end else begin
          mosi_d  = tx_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cs_q    <= CS_IDLE;
      mosi_q  <= 1'b0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      mdr_q   <= mdr_d;
    end
  end

  // SCLK rises mid-bit so the slave samples MOSI half a cycle after it changes.
  assign SCLK               = (state_q == SHIFT) && !clk;
  assign CS                 = cs_q;
  assign MOSI               = mosi_q;
  assign masterDataReceived = mdr_q;
endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master against a word-level SPI slave model.
module tb_spi_master;
  logic       clk, reset, start, SCLK, MOSI, MISO;
  logic [1:0] slaveSelect;
  logic [7:0] masterDataToSend, masterDataReceived;
  logic [0:2] CS;

  int   n_cmp = 0, n_bad = 0;
  logic [7:0] mdr_model = 8'h00;

  spi_master dut (
    .clk(clk), .reset(reset), .start(start), .slaveSelect(slaveSelect),
    .masterDataToSend(masterDataToSend), .masterDataReceived(masterDataReceived),
    .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Position in the word of the k-th bit on the wire.
  function automatic int wire_pos(input int k);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return 7 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic [2:0] cs_for(input logic [1:0] sel);
    logic [2:0] v;
    v = 3'b111;
    v[2 - sel] = 1'b0;  // CS[0] is the leftmost bit
    return v;
  endfunction

  // One transfer request; slave answers with sw. Rejected when sel == 3.
  task automatic xfer(input logic [7:0] tx, input logic [1:0] sel, input logic [7:0] sw);
    logic [2:0] cs_exp;
    @(negedge clk);
    start = 1'b1; masterDataToSend = tx; slaveSelect = sel; MISO = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; masterDataToSend = 8'($urandom); slaveSelect = 2'($urandom);
    if (sel == 2'd3) begin
      for (int c = 0; c < 10; c++) begin
        chk("rej_cs", CS, 3'b111);
        chk("rej_sclk", SCLK, 1'b0);
        @(negedge clk);
      end
      chk("rej_mdr", masterDataReceived, mdr_model);
      return;
    end
    cs_exp = cs_for(sel);
    chk("setup_cs", CS, cs_exp);
    chk("setup_sclk", SCLK, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("mosi_b%0d", k), MOSI, tx[wire_pos(k)]);
      chk("shift_sclk", SCLK, 1'b1);
      chk("shift_cs", CS, cs_exp);
      MISO = sw[wire_pos(k)];
      start = (k < 7) ? 1'($urandom) : 1'b0;  // must be ignored mid-transfer
      slaveSelect = 2'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mdr_model = sw;
    chk("rx_word", masterDataReceived, mdr_model);
    chk("end_cs", CS, 3'b111);
    chk("end_mosi", MOSI, 1'b0);
    chk("end_sclk", SCLK, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; slaveSelect = 2'd0; masterDataToSend = 8'h00; MISO = 1'b0;
    #3;
    chk("rst_cs", CS, 3'b111);
    chk("rst_sclk", SCLK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_mdr", masterDataReceived, 8'h00);
    #2 reset = 1'b0;

    xfer(8'h27, 2'd0, 8'h53);
    xfer(8'hA5, 2'd2, 8'hFF);
    xfer(8'h3C, 2'd3, 8'h00);
    chk("hold_mdr", masterDataReceived, 8'hFF);

    // Abort mid-transfer: reset shortly after edge 5.
    @(negedge clk);
    start = 1'b1; masterDataToSend = 8'h81; slaveSelect = 2'd1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    mdr_model = 8'h00;
    chk("abort_cs", CS, 3'b111);
    chk("abort_mdr", masterDataReceived, mdr_model);
    chk("abort_mosi", MOSI, 1'b0);
    @(negedge clk) reset = 1'b0;
    chk("abort_sclk", SCLK, 1'b0);
    xfer(8'h0F, 2'd1, 8'h00);

    for (int i = 0; i < 20; i++)
      xfer(8'($urandom), 2'($urandom_range(0, 3)), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI bus master that shifts one 8-bit word out on MOSI while shifting one 8-bit word in from MISO, LSB first, addressing one of three slaves through active-low chip selects. It sits between a local controller, which issues a one-cycle `start` pulse with data and slave index, and the off-chip SPI bus. SCLK is derived from the system clock, so the bit rate equals the clk rate.

## Interface
- DATA_WIDTH, 8, transfer word length in bits.
- NUM_SLAVES, 3, number of chip-select lines.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  transfer request, sampled on rising clk; a one-cycle pulse is sufficient.
- slaveSelect  input  2  index of the target slave, 0..2.
- masterDataToSend  input  8  word to transmit, captured with `start`.
- masterDataReceived  output  8  last complete word received from MISO.
- SCLK  output  1  SPI clock.
- CS  output  [0:2]  chip selects, active low, one per slave.
- MOSI  output  1  serial data to the slave.
- MISO  input  1  serial data from the slave.

## Operation
- Reset (asynchronous, active-high) forces:
  - state IDLE, CS = 3'b111, SCLK = 0, MOSI = 0;
  - masterDataReceived = 0, bit counter = 0.
- States: IDLE -> SETUP -> SHIFT -> IDLE.
- IDLE:
  - On a rising edge with start = 1 and slaveSelect <= 2: capture masterDataToSend into the TX register, clear the RX register, drive CS[slaveSelect] low, go to SETUP.
  - start with slaveSelect = 3 is ignored and the block stays IDLE.
- SETUP, one cycle: at the next rising edge drive MOSI = tx[0], counter = 0, go to SHIFT.
- SHIFT, at each rising edge:
  - sample MISO into rx[counter];
  - if counter < 7, drive MOSI = tx[counter+1] and increment the counter;
  - when counter = 7, load masterDataReceived with the full RX word, including the bit sampled at that edge, release CS (all ones), drive MOSI = 0 and go to IDLE.
- start asserted while in SETUP or SHIFT is ignored.
- masterDataReceived holds its value between transfers.
- Reset asserted mid-transfer aborts the transfer immediately: CS goes high and the RX word is discarded.

## Timing
- Cycle 0 is the edge that accepts start; CS goes low at that edge.
- MOSI carries bit k from edge k+1 until edge k+2, for k = 0..7.
- MISO bit k is sampled at edge k+2.
  - The slave must present bit 0 from before edge 2 and bit k in the interval between edges k+1 and k+2.
- masterDataReceived is valid immediately after edge 9.
- CS is high after edge 9. The next start is accepted at edge 10 at the earliest.
- SCLK = ~clk while in SHIFT (rises mid-bit); SCLK is 0 otherwise.
  - The slave samples MOSI on the rising edge of SCLK.
- Total transfer: 10 clk edges from start to IDLE.

## Configuration
- SPI_MASTER_MSB_FIRST_EN
  - Defined: both directions are MSB first. MOSI sends tx[7] down to tx[0]; the first sampled MISO bit goes to rx[7].
  - Undefined (default): LSB first, as described above.

## Structure
- Shared package `spi_pkg`:
  - state enum (IDLE, SETUP, SHIFT);
  - DATA_WIDTH and NUM_SLAVES constants;
  - CS_IDLE constant (all ones).
- One natural sub-module: `spi_shift_reg`, holding the TX/RX registers and the bit counter with load, shift and done outputs. The FSM and the CS/SCLK logic stay in `spi_master`.

## Test plan
- Reset held from 0 to 5 ns -> CS = 111, SCLK = 0, MOSI = 0, masterDataReceived = 0.
- Transfer, LSB-first: start with masterDataToSend = 0x27, slaveSelect = 0, slave drives 0x53 LSB first.
  - MOSI bits across edges 1..8 read 1,1,1,0,0,1,0,0 (0x27).
  - masterDataReceived = 0x53 after edge 9.
  - CS = 011 during the transfer, 111 afterwards.
- slaveSelect = 2, send 0xA5, MISO held high -> CS = 110 during the transfer; received word = 0xFF.
- start with slaveSelect = 3 -> CS stays 111, no SCLK pulses, masterDataReceived unchanged.
- Reset at edge 5 of a transfer -> CS = 111 immediately, masterDataReceived = 0.
  - A following start with 0x0F and MISO = 0 completes with received word 0x00.
- With SPI_MASTER_MSB_FIRST_EN: send 0x27, slave returns 0x53 MSB first -> MOSI reads 0,0,1,0,0,1,1,1; received word = 0x53.
